arbiter: RTL and testbench
==========================

# arbiter

Three-requester arbiter that grants exclusive ownership of one shared resource to one of r0/r1/r2 at a time. A grant is held for as long as the owner keeps its request asserted; on release, ownership passes to the highest-priority pending requester. The arbiter sits between the requesting agents and the shared resource; grants are registered, one-hot-or-zero, and drive the resource mux and enable directly.

## Interface
- Parameters: none.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk edge.
- r0  input  1  request from agent 0 (highest fixed priority).
- r1  input  1  request from agent 1.
- r2  input  1  request from agent 2 (lowest fixed priority).
- g0  output  1  grant to agent 0, registered.
- g1  output  1  grant to agent 1, registered.
- g2  output  1  grant to agent 2, registered.

## Operation
- Moore FSM, four states: IDLE, GNT0, GNT1, GNT2. Outputs decode state only: gN=1 only in GNTN; all grants 0 in IDLE.
- Invariant: at most one of g0/g1/g2 is high in any cycle.
- IDLE: r0 -> GNT0; else r1 -> GNT1; else r2 -> GNT2; else stay IDLE.
- GNTn with rn=1: stay in GNTn. No preemption, even when a higher-priority request arrives.
- GNTn with rn=0: release. Go directly to the highest-priority other pending request; if none is pending, go to IDLE. No mandatory idle cycle between owners.
- A requester that deasserts before it is granted is simply dropped. Requests are not latched.
- Requests are level-sensitive. The arbiter does not require a request to remain high after release.
- Reset: state=IDLE, so g0=g1=g2=0. Reset overrides all request inputs and applies at any point, including while a grant is held.

## Timing
- Grant latency: a request sampled high at rising edge k, with the arbiter in IDLE, produces its grant visible from edge k (after clk-to-q) onward, i.e. in the cycle following sampling.
- Release latency: the owner's request sampled low at edge k causes its grant to drop at edge k. The next owner's grant rises at the same edge.
- Reset: reset high at edge k forces all grants low after edge k. The first grant can appear at the first edge where reset=0 and a request is high.
- Inputs must meet setup/hold to clk. No combinational path from any input to any output.

## Configuration
- Macro ARBITER_ROUND_ROBIN_EN.
- Undefined (default): fixed priority r0 > r1 > r2 for every selection, from IDLE and on release.
- Defined: on release from GNTn, and from IDLE, priority starts at the requester after the last owner, in order 0->1->2->0. The last-owner register resets to 2, so the first selection after reset is ordered 0,1,2. Hold and no-preemption rules are unchanged.

## Test plan
- Reset: reset=1 for 1 cycle with all r=1 -> g0=g1=g2=0 during reset. At the first edge with reset=0: g0=1.
- Single requests: r0 pulsed for 1 cycle -> g0=1 for exactly 1 cycle, then IDLE. Repeat with r1 alone (g1 only) and r2 alone (g2 only).
- Contention, fixed priority: r0=r1=r2=1 together -> g0. Drop r0 -> g1 at the next edge with no idle gap. Drop r1 two cycles later -> g2. Drop r2 -> all grants 0.
- No preemption: r2=1 so g2 is granted; then r0=1 while r2 is held -> g2 stays 1 and g0 stays 0 until r2=0; then g0=1 at the next edge.
- Reset mid-grant: g1 held with r1=1, assert reset for 1 cycle -> all grants 0. After reset=0 with r1 still 1 -> g1=1 again.
- One-hot check: random requests for 1000 cycles -> never more than one grant high. Every grant is preceded by its request sampled high.
- (ARBITER_ROUND_ROBIN_EN) All three requests held, each released after 1 grant cycle and then reasserted -> grant order 0,1,2,0,1,2.

Source files
------------

// File: rtl/arbiter.sv
// rtl/arbiter.sv - three-requester hold-until-release arbiter, optional ARBITER_ROUND_ROBIN_EN rotation
module arbiter (
    input  logic clk,
    input  logic reset,
    input  logic r0,
    input  logic r1,
    input  logic r2,
    output logic g0,
    output logic g1,
    output logic g2
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        GNT2 = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;
    state_t w_pick;

`ifdef ARBITER_ROUND_ROBIN_EN
    // Index of the most recent owner; selection starts at the requester after it.
    logic [1:0] r_last;

    // Rotating-priority choice among current requests, starting after the last owner.
    always_comb begin
        w_pick = IDLE;
        case (r_last)
            2'd0: begin
                if      (r1) w_pick = GNT1;
                else if (r2) w_pick = GNT2;
                else if (r0) w_pick = GNT0;
            end
            2'd1: begin
                if      (r2) w_pick = GNT2;
                else if (r0) w_pick = GNT0;
                else if (r1) w_pick = GNT1;
            end
            default: begin
                if      (r0) w_pick = GNT0;
                else if (r1) w_pick = GNT1;
                else if (r2) w_pick = GNT2;
            end
        endcase
    end

    // Remember who owns the resource whenever a grant is (re)established.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 2'd2;
        end else begin
            case (w_next)
                GNT0:    r_last <= 2'd0;
                GNT1:    r_last <= 2'd1;
                GNT2:    r_last <= 2'd2;
                default: r_last <= r_last;
            endcase
        end
    end
`else
    // Fixed-priority choice among current requests: r0 > r1 > r2.
    always_comb begin
        w_pick = IDLE;
        if      (r0) w_pick = GNT0;
        else if (r1) w_pick = GNT1;
        else if (r2) w_pick = GNT2;
    end
`endif

    // Next state: owners hold while requesting; on release hand over directly.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_pick;
            GNT0:    if (!r0) w_next = w_pick;
            GNT1:    if (!r1) w_next = w_pick;
            GNT2:    if (!r2) w_next = w_pick;
            default: w_next = IDLE;
        endcase
    end

    // State register; reset forces IDLE regardless of requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grants decode the registered state only, so they are one-hot-or-zero and glitch-free.
    assign g0 = (r_state == GNT0);
    assign g1 = (r_state == GNT1);
    assign g2 = (r_state == GNT2);

endmodule

// File: tb/tb_arbiter.sv
// tb/tb_arbiter.sv - directed and random scoreboard bench for arbiter
module tb_arbiter;

    logic clk;
    logic reset;
    logic r0, r1, r2;
    logic g0, g1, g2;

    int n_assert;
    int n_fail;

    logic [2:0] sb_q[$];
    logic [2:0] m_g;
    int         m_last;

    arbiter dut (
        .clk   (clk),
        .reset (reset),
        .r0    (r0),
        .r1    (r1),
        .r2    (r2),
        .g0    (g0),
        .g1    (g1),
        .g2    (g2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] bit_of(input int idx);
        logic [2:0] v;
        v = 3'b000;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Reference selection: first pending requester scanning from a start index.
    function automatic logic [2:0] model_pick(input logic [2:0] req, input int start);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            if (req[(start + i) % 3]) res = bit_of((start + i) % 3);
        end
        return res;
    endfunction

    // Advances the bench model by one edge and returns the expected grant vector.
    function automatic logic [2:0] model_step(input logic rst, input logic [2:0] req);
        int start;
`ifdef ARBITER_ROUND_ROBIN_EN
        start = (m_last + 1) % 3;
`else
        start = 0;
`endif
        if (rst) begin
            m_g    = 3'b000;
            m_last = 2;
        end else if ((m_g & req) == 3'b000) begin
            m_g = model_pick(req, start);
            for (int i = 0; i < 3; i++) if (m_g[i]) m_last = i;
        end
        return m_g;
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, push its expectation, clock, then pop and compare.
    task automatic step(input string tag, input logic rst, input logic [2:0] req, input logic [2:0] exp);
        logic [2:0] e;
        logic [2:0] obs;
        reset = rst;
        {r2, r1, r0} = req;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        obs = {g2, g1, g0};
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s scoreboard empty observed=%b expected=entry", tag, obs);
        end else begin
            e = sb_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    initial begin
        logic [2:0] req;
        logic       rst;
        logic [2:0] exp;
        logic [2:0] obs;
        n_assert = 0;
        n_fail   = 0;
        m_g      = 3'b000;
        m_last   = 2;
        reset    = 1'b1;
        {r2, r1, r0} = 3'b000;
        #2;

        // Reset with all requests high, then first grant goes to r0.
        step("reset_all_req",   1'b1, 3'b111, 3'b000);
        step("first_after_rst", 1'b0, 3'b111, 3'b001);

        // Contention hand-over without idle gaps.
        step("drop_r0",        1'b0, 3'b110, 3'b010);
        step("hold_r1_a",      1'b0, 3'b110, 3'b010);
        step("drop_r1",        1'b0, 3'b100, 3'b100);
        step("drop_r2",        1'b0, 3'b000, 3'b000);

        // Single one-cycle requests.
        step("pulse_r0",       1'b0, 3'b001, 3'b001);
        step("after_r0",       1'b0, 3'b000, 3'b000);
        step("pulse_r1",       1'b0, 3'b010, 3'b010);
        step("after_r1",       1'b0, 3'b000, 3'b000);
        step("pulse_r2",       1'b0, 3'b100, 3'b100);
        step("after_r2",       1'b0, 3'b000, 3'b000);

        // No preemption of a lower-priority owner.
        step("np_grant_r2",    1'b0, 3'b100, 3'b100);
        step("np_r0_arrives",  1'b0, 3'b101, 3'b100);
        step("np_r0_waits",    1'b0, 3'b101, 3'b100);
        step("np_release_r2",  1'b0, 3'b001, 3'b001);
        step("np_idle",        1'b0, 3'b000, 3'b000);

        // Reset while a grant is held.
        step("mid_grant_r1",   1'b0, 3'b010, 3'b010);
        step("mid_hold_r1",    1'b0, 3'b010, 3'b010);
        step("mid_reset",      1'b1, 3'b010, 3'b000);
        step("mid_regrant",    1'b0, 3'b010, 3'b010);
        step("mid_idle",       1'b0, 3'b000, 3'b000);

`ifdef ARBITER_ROUND_ROBIN_EN
        // Rotation: each owner releases after one cycle and re-requests.
        step("rr_reset",       1'b1, 3'b111, 3'b000);
        step("rr_g0_a",        1'b0, 3'b111, 3'b001);
        step("rr_g1_a",        1'b0, 3'b110, 3'b010);
        step("rr_g2_a",        1'b0, 3'b101, 3'b100);
        step("rr_g0_b",        1'b0, 3'b011, 3'b001);
        step("rr_g1_b",        1'b0, 3'b110, 3'b010);
        step("rr_g2_b",        1'b0, 3'b101, 3'b100);
`endif

        // Random traffic against the bench model, with invariant checks.
        step("rand_reset", 1'b1, 3'b000, model_step(1'b1, 3'b000));
        for (int c = 0; c < 1000; c++) begin
            req = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 49) == 0);
            exp = model_step(rst, req);
            step("rand_grant", rst, req, exp);
            obs = {g2, g1, g0};
            check("rand_onehot", {2'b00, ($countones(obs) <= 1)}, 3'b001);
            check("rand_req_before_grant", obs & ~req, 3'b000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
